tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter: WIDTH, default 8, width of divide ratio, burst length and pulse count.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstb  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: div  input  WIDTH  divide ratio; tick period = div+1 cycles.
REQ-005 Port: load  input  1  strobe; latches div and burst_len.
REQ-006 Port: start  input  1  strobe; begins a run.
REQ-007 Port: stop  input  1  strobe; aborts a run.
REQ-008 Port: mode  input  1  sampled with start; 0 = continuous, 1 = burst.
REQ-009 Port: burst_len  input  WIDTH  number of ticks per burst.
REQ-010 Port: en  output  1  registered one-cycle tick; drives the downstream counter's en.
REQ-011 Port: busy  output  1  high while in RUN.
REQ-012 Port: done  output  1  one-cycle pulse at burst completion.
REQ-013 Port: pulse_cnt  output  WIDTH  ticks issued in current or last run.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; all outputs registered.
REQ-015 load in IDLE SHALL latch div into div_q and burst_len into len_q at that edge; load outside IDLE SHALL be ignored.
REQ-016 start in IDLE (stop low) SHALL move to RUN, latch mode, clear prescaler cnt and pulse_cnt at that edge.
REQ-017 In RUN, each edge with cnt == div_q SHALL set en=1, cnt=0, pulse_cnt+1; otherwise en=0, cnt+1.
REQ-018 Start sampled at edge k: first en high in the cycle after edge k+div_q+1, then every div_q+1 cycles; div_q=0 gives en every cycle.
REQ-019 Continuous mode SHALL run until stop; pulse_cnt wraps 2^WIDTH-1 -> 0 silently.
REQ-020 Burst mode SHALL issue exactly len_q ticks (len_q=0 means 2^WIDTH), then enter DONE on the edge issuing the last tick.
REQ-021 DONE SHALL last one cycle with done=1, busy=0, en=0, then return to IDLE.
REQ-022 stop in RUN SHALL go to IDLE at that edge; en=0 from the next cycle; done not asserted; pulse_cnt held.
REQ-023 stop and start together in IDLE: stop wins, remain IDLE; start while RUN or DONE ignored.
REQ-024 Final tick and stop on the same edge in burst mode: stop wins, go to IDLE, no done, that tick is not issued.
REQ-025 busy SHALL be 1 exactly in RUN.

Reset
REQ-026 rstb low at a rising edge SHALL force IDLE, en=0, busy=0, done=0, pulse_cnt=0, cnt=0, div_q=3, len_q=1, mode=0.
REQ-027 Reset mid-run SHALL abort immediately without done; reset SHALL take priority over all inputs.

Configuration
REQ-028 Macro TICK_GEN_SYNC_EN defined: start and stop SHALL each pass a 2-flop synchronizer (reset to 0) before the FSM, adding 2 cycles to every start and stop response.
REQ-029 TICK_GEN_SYNC_EN undefined: start and stop SHALL be used directly, latencies as in REQ-018 and REQ-022.

Verification
REQ-030 Reset, load div=3 burst_len=4, start mode=1 -> en high 4 times, spaced 4 cycles apart, first 4 cycles after start; done 1 cycle after last en; pulse_cnt=4.
REQ-031 div=0, mode=0, start, 300 cycles, stop -> en high every cycle; pulse_cnt wraps past 255 and equals 300 mod 256 = 44 after stop.
REQ-032 Load div=7 during RUN at div 2 -> period stays 3 cycles; new div takes effect only after return to IDLE and a fresh load.
REQ-033 Burst len=0, div=0 -> 256 ticks, then done.
REQ-034 rstb low mid-burst after 2 of 5 ticks -> en, busy, pulse_cnt = 0 next cycle; no done; div_q=3 afterwards.
REQ-035 With TICK_GEN_SYNC_EN, repeat REQ-030 -> identical en pattern shifted 2 cycles later.

Source files
------------

// File: rtl/tick_gen_if.sv
// tick_gen_if: control and status bundle between a tick_gen and its controller.
interface tick_gen_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] div, burst_len, pulse_cnt;
  logic load, start, stop, mode, en, busy, done;
  modport master(output div, burst_len, load, start, stop, mode, input en, busy, done, pulse_cnt);
  modport slave(input div, burst_len, load, start, stop, mode, output en, busy, done, pulse_cnt);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: programmable tick generator with continuous and burst modes.
// Define TICK_GEN_SYNC_EN to pass start/stop through 2-flop synchronizers.
module tick_gen #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rstb,
  tick_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n, div_q, len_q, pcnt, pcnt_n, pinc;
  logic mode_q, en_q, busy_q, done_q, en_n, done_n, start_i, stop_i, go, tick, fire;
`ifdef TICK_GEN_SYNC_EN
  logic [1:0] start_sr, stop_sr;
  always_ff @(posedge clk)
    if (!rstb) begin
      start_sr <= '0;
      stop_sr <= '0;
    end else begin
      start_sr <= {start_sr[0], bus.start};
      stop_sr <= {stop_sr[0], bus.stop};
    end
  assign start_i = start_sr[1];
  assign stop_i = stop_sr[1];
`else
  assign start_i = bus.start;
  assign stop_i = bus.stop;
`endif
  assign go = state == IDLE && start_i && !stop_i;
  assign tick = cnt == div_q;
  assign pinc = pcnt + WIDTH'(1);
  assign fire = state == RUN && !stop_i && tick;
  // len_q == 0 matches when pinc wraps to 0, giving 2^WIDTH ticks
  always_comb
    state_n = go ? RUN : (state != RUN || stop_i) ? IDLE : (fire && mode_q && pinc == len_q) ? DONE : RUN;
  always_comb begin
    en_n = fire;
    done_n = state == DONE;
    cnt_n = (state == RUN && !stop_i && !tick) ? cnt + WIDTH'(1) : '0;
    pcnt_n = go ? '0 : fire ? pinc : pcnt;
  end
  always_ff @(posedge clk)
    if (!rstb) begin
      state <= IDLE;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt <= '0;
      pcnt <= '0;
      div_q <= WIDTH'(3);
      len_q <= WIDTH'(1);
      mode_q <= 1'b0;
    end else begin
      state <= state_n;
      en_q <= en_n;
      busy_q <= state_n == RUN;
      done_q <= done_n;
      cnt <= cnt_n;
      pcnt <= pcnt_n;
      if (state == IDLE && bus.load) begin
        div_q <= bus.div;
        len_q <= bus.burst_len;
      end
      if (go) mode_q <= bus.mode;
    end
  assign bus.en = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pulse_cnt = pcnt;
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: vector table, corner sequences and random run against a tick-level model.
module tb_tick_gen;
  localparam int W = 8;
`ifdef TICK_GEN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int errors = 0;
  int checks = 0;
  tick_gen_if #(.WIDTH(W)) bus();
  tick_gen #(.WIDTH(W)) dut(.clk(clk), .rstb(rstb), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    bit rstb, load, start, stop, mode;
    int div, bl;
    bit en, busy, done;
    int pc;
  } vec_t;
  vec_t tbl[$];

  int m_phase, m_div, m_len, m_mode, m_t, m_n;
  bit m_en, m_done, sd0, sd1, pd0, pd1;

  // Model: ticks fall on every (div+1)-th edge counted since the run began.
  task automatic model_step();
    bit s, p;
    s = (LAT == 2) ? sd1 : bus.start;
    p = (LAT == 2) ? pd1 : bus.stop;
    if (!rstb) begin
      m_phase = 0; m_div = 3; m_len = 1; m_mode = 0; m_t = 0; m_n = 0;
      m_en = 0; m_done = 0; sd0 = 0; sd1 = 0; pd0 = 0; pd1 = 0;
    end else begin
      sd1 = sd0; sd0 = bus.start; pd1 = pd0; pd0 = bus.stop;
      m_en = 0; m_done = 0;
      case (m_phase)
        0: begin
          if (bus.load) begin
            m_div = int'(bus.div);
            m_len = bus.burst_len == 0 ? 256 : int'(bus.burst_len);
          end
          if (s && !p) begin m_phase = 1; m_mode = int'(bus.mode); m_t = 0; m_n = 0; end
        end
        1: if (p) m_phase = 0;
           else begin
             m_t++;
             if (m_t % (m_div + 1) == 0) begin
               m_en = 1; m_n++;
               if (m_mode == 1 && m_n == m_len) m_phase = 2;
             end
           end
        default: begin m_done = 1; m_phase = 0; end
      endcase
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit ld, bit st, bit sp, bit md, int dv, int bl);
    rstb = r; bus.load = ld; bus.start = st; bus.stop = sp; bus.mode = md;
    bus.div = W'(dv); bus.burst_len = W'(bl);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model en", int'(bus.en), int'(m_en));
    check("model busy", int'(bus.busy), m_phase == 1 ? 1 : 0);
    check("model done", int'(bus.done), int'(m_done));
    check("model pulse_cnt", int'(bus.pulse_cnt), m_n % 256);
  endtask

  task automatic idle(int n);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  task automatic start_run(bit md);
    drive(1, 0, 1, 0, md, 0, 0);
    cyc();
    idle(LAT);
  endtask

  task automatic load_cfg(int dv, int bl);
    drive(1, 1, 0, 0, 0, dv, bl);
    cyc();
  endtask

  function automatic vec_t mk(bit r, bit ld, bit st, bit md, int dv, int bl, bit en, bit busy, bit done, int pc);
    vec_t v;
    v.rstb = r; v.load = ld; v.start = st; v.stop = 0; v.mode = md; v.div = dv; v.bl = bl;
    v.en = en; v.busy = busy; v.done = done; v.pc = pc;
    return v;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 4, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 3, 4, 0, LAT == 0, 0, 0));
    for (int r = 3; r <= 20 + LAT; r++) begin
      int j;
      j = r - 2 - LAT;
      if (j < 0) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      else if (j <= 15) tbl.push_back(mk(1, 0, 0, 0, 0, 0, j % 4 == 0 && j > 0, 1, 0, j / 4));
      else if (j == 16) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 4));
      else if (j == 17) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 4));
      else tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    end
    foreach (tbl[i]) begin
      drive(tbl[i].rstb, tbl[i].load, tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].div, tbl[i].bl);
      cyc();
      check($sformatf("vec%0d en", i), int'(bus.en), int'(tbl[i].en));
      check($sformatf("vec%0d busy", i), int'(bus.busy), int'(tbl[i].busy));
      check($sformatf("vec%0d done", i), int'(bus.done), int'(tbl[i].done));
      check($sformatf("vec%0d pulse_cnt", i), int'(bus.pulse_cnt), tbl[i].pc);
    end

    // continuous div=0: 300 ticks, stop wraps count to 44
    load_cfg(0, 1);
    start_run(0);
    idle(300 - LAT);
    drive(1, 0, 0, 1, 0, 0, 0);
    cyc();
    idle(LAT);
    check("wrap pulse_cnt", int'(bus.pulse_cnt), 44);
    check("wrap busy", int'(bus.busy), 0);
    idle(1);
    check("wrap en after stop", int'(bus.en), 0);

    // load during run is ignored
    load_cfg(2, 1);
    start_run(0);
    drive(1, 1, 0, 0, 0, 7, 9);
    repeat (12) cyc();
    check("run load ignored", int'(bus.pulse_cnt), 4);
    drive(1, 0, 0, 1, 0, 0, 0);
    cyc();
    idle(LAT + 1);
    load_cfg(7, 1);
    start_run(0);
    idle(7);
    check("new div not yet", int'(bus.pulse_cnt), 0);
    idle(1);
    check("new div tick", int'(bus.en), 1);
    drive(1, 0, 0, 1, 0, 0, 0);
    cyc();
    idle(LAT + 1);

    // burst len=0 means 256 ticks
    load_cfg(0, 0);
    start_run(1);
    idle(256);
    check("len0 last en", int'(bus.en), 1);
    check("len0 pulse_cnt", int'(bus.pulse_cnt), 0);
    idle(1);
    check("len0 done", int'(bus.done), 1);
    idle(1);

    // reset mid-burst after 2 of 5 ticks
    load_cfg(3, 5);
    start_run(1);
    idle(8);
    check("pre-reset pulse_cnt", int'(bus.pulse_cnt), 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("reset en", int'(bus.en), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset pulse_cnt", int'(bus.pulse_cnt), 0);
    idle(1);
    check("reset no done", int'(bus.done), 0);
    start_run(1);
    idle(4);
    check("reset div_q=3 tick", int'(bus.en), 1);
    idle(1);
    check("reset len_q=1 done", int'(bus.done), 1);

    // stop on final burst tick wins
    load_cfg(1, 2);
    start_run(1);
    idle(3 - LAT);
    drive(1, 0, 0, 1, 0, 0, 0);
    cyc();
    idle(LAT);
    check("stop-final en", int'(bus.en), 0);
    check("stop-final pulse_cnt", int'(bus.pulse_cnt), 1);
    idle(1);
    check("stop-final no done", int'(bus.done), 0);

    // start and stop together in idle
    drive(1, 0, 1, 1, 0, 0, 0);
    cyc();
    idle(LAT + 2);
    check("start+stop idle", int'(bus.busy), 0);

    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 6));
      cyc();
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
